// File: rtl/issue_rat_freelist.sv
// Circular free list of physical register indices for the rename stage.
// It has one allocation pop and two push ports (release and abandon), and a free-bitmap shadow that flags double frees.
module issue_rat_freelist #(
    parameter int PRF_WIDTH = 6,
    parameter int ARF_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 o_alloc_valid,
    input  logic                 i_alloc_ready,
    output logic [PRF_WIDTH-1:0] o_alloc_prf,
    input  logic                 i_abandoned_valid,
    output logic                 o_abandoned_ready,
    input  logic [PRF_WIDTH-1:0] i_abandoned_prf,
    input  logic                 i_release_valid,
    output logic                 o_release_ready,
    input  logic [PRF_WIDTH-1:0] i_release_prf,
    output logic [PRF_WIDTH:0]   o_count,
    output logic                 o_error
);

    localparam int PRF_COUNT = 1 << PRF_WIDTH;
    localparam logic [PRF_WIDTH:0] FULL_COUNT  = (PRF_WIDTH+1)'(PRF_COUNT);
    localparam logic [PRF_WIDTH:0] INIT_COUNT  = (PRF_WIDTH+1)'(PRF_COUNT - ARF_COUNT);

    logic [PRF_WIDTH-1:0] mem_q [PRF_COUNT];
    logic [PRF_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [PRF_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [PRF_COUNT-1:0] free_q, free_d;
    logic                 error_q, error_d;

    logic [PRF_WIDTH:0]   count;
    logic                 pop;
    logic                 rel_fire;
    logic                 ab_fire;
    logic [PRF_WIDTH-1:0] rel_addr;
    logic [PRF_WIDTH-1:0] ab_addr;
    logic                 dup_free;

    // Readiness depends on the registered count only, so a same-cycle pop never opens a slot.
    assign count             = wr_ptr_q - rd_ptr_q;
    assign o_count           = count;
    assign o_alloc_valid     = (count != '0);
    assign o_alloc_prf       = mem_q[rd_ptr_q[PRF_WIDTH-1:0]];
    assign o_release_ready   = (count != FULL_COUNT);
    assign o_abandoned_ready = (count < (FULL_COUNT - 1'b1));
    assign o_error           = error_q;

    assign pop      = o_alloc_valid & i_alloc_ready;
    assign rel_fire = i_release_valid & o_release_ready;
    assign ab_fire  = i_abandoned_valid & o_abandoned_ready;
    assign rel_addr = wr_ptr_q[PRF_WIDTH-1:0];
    assign ab_addr  = wr_ptr_q[PRF_WIDTH-1:0] + PRF_WIDTH'(rel_fire);

    assign dup_free = (rel_fire & free_q[i_release_prf])
                    | (ab_fire & (free_q[i_abandoned_prf]
                                  | (rel_fire & (i_release_prf == i_abandoned_prf))));

    // The pop clears its bit before the pushes set theirs, so a push always leaves its PRF marked free.
    always_comb begin
        rd_ptr_d = rd_ptr_q + (PRF_WIDTH+1)'(pop);
        wr_ptr_d = wr_ptr_q + (PRF_WIDTH+1)'(rel_fire) + (PRF_WIDTH+1)'(ab_fire);
        free_d   = free_q;
        if (pop)      free_d[o_alloc_prf]     = 1'b0;
        if (rel_fire) free_d[i_release_prf]   = 1'b1;
        if (ab_fire)  free_d[i_abandoned_prf] = 1'b1;
        error_d  = error_q | dup_free;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PRF_COUNT; k++) begin
                mem_q[k]  <= (k < PRF_COUNT - ARF_COUNT) ? PRF_WIDTH'(ARF_COUNT + k) : '0;
                free_q[k] <= (k >= ARF_COUNT);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= INIT_COUNT;
            error_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            free_q   <= free_d;
            error_q  <= error_d;
            if (rel_fire) mem_q[rel_addr] <= i_release_prf;
            if (ab_fire)  mem_q[ab_addr]  <= i_abandoned_prf;
        end
    end

endmodule

// File: tb/tb_issue_rat_freelist.sv
// Directed bench for issue_rat_freelist: vector table plus hand sequences for fill, error, wrap and reset.
module tb_issue_rat_freelist;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       allocValid;
    logic       allocReady = 1'b0;
    logic [5:0] allocPrf;
    logic       abValid = 1'b0;
    logic       abReady;
    logic [5:0] abPrf = '0;
    logic       relValid = 1'b0;
    logic       relReady;
    logic [5:0] relPrf = '0;
    logic [6:0] count;
    logic       error;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       ar;
        logic       rv;
        logic [5:0] rp;
        logic       av;
        logic [5:0] ap;
        logic       ev;
        logic [5:0] ep;
        logic [6:0] ec;
        logic       err;
        logic       rr;
        logic       abr;
    } vec_t;

    vec_t tbl [10];
    int   freeQ [$];
    int   heldQ [$];

    issue_rat_freelist #(.PRF_WIDTH(6), .ARF_COUNT(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .o_alloc_valid     (allocValid),
        .i_alloc_ready     (allocReady),
        .o_alloc_prf       (allocPrf),
        .i_abandoned_valid (abValid),
        .o_abandoned_ready (abReady),
        .i_abandoned_prf   (abPrf),
        .i_release_valid   (relValid),
        .o_release_ready   (relReady),
        .i_release_prf     (relPrf),
        .o_count           (count),
        .o_error           (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are then stable until the next rising edge.
    task automatic applyStimulus(input logic ar, input logic rv, input logic [5:0] rp,
                                 input logic av, input logic [5:0] ap);
        allocReady = ar;
        relValid   = rv;
        relPrf     = rp;
        abValid    = av;
        abPrf      = ap;
        @(posedge clk);
        @(negedge clk);
        allocReady = 1'b0;
        relValid   = 1'b0;
        abValid    = 1'b0;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, int'(count), 32);
        checkOutput({tag, "_valid"}, int'(allocValid), 1);
        checkOutput({tag, "_prf"}, int'(allocPrf), 32);
        checkOutput({tag, "_relReady"}, int'(relReady), 1);
        checkOutput({tag, "_abReady"}, int'(abReady), 1);
        checkOutput({tag, "_error"}, int'(error), 0);
    endtask

    task automatic drainInitial(input string tag);
        for (int i = 0; i < 32; i++) begin
            checkOutput({tag, "_drainPrf"}, int'(allocPrf), 32 + i);
            checkOutput({tag, "_drainCount"}, int'(count), 32 - i);
            applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        end
        checkOutput({tag, "_emptyValid"}, int'(allocValid), 0);
        checkOutput({tag, "_emptyCount"}, int'(count), 0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 6'd5,  1'b1, 6'd7,  1'b0, 6'd0,  7'd0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd5,  7'd2, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd7,  7'd1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 6'd3,  1'b0, 6'd0,  1'b0, 6'd0,  7'd0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd9,  1'b1, 6'd3,  7'd1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 6'd10, 1'b1, 6'd11, 1'b1, 6'd3,  7'd2, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd9,  7'd3, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd10, 7'd2, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd11, 7'd1, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  7'd0, 1'b0, 1'b1, 1'b1};

        $display("[TB] reset and initial drain");
        resetDut();
        checkResetState("reset");
        drainInitial("drain");

        $display("[TB] vector table from empty list");
        for (int v = 0; v < 10; v++) begin
            checkOutput($sformatf("tbl%0d_valid", v), int'(allocValid), int'(tbl[v].ev));
            if (tbl[v].ev)
                checkOutput($sformatf("tbl%0d_prf", v), int'(allocPrf), int'(tbl[v].ep));
            checkOutput($sformatf("tbl%0d_count", v), int'(count), int'(tbl[v].ec));
            checkOutput($sformatf("tbl%0d_error", v), int'(error), int'(tbl[v].err));
            checkOutput($sformatf("tbl%0d_relReady", v), int'(relReady), int'(tbl[v].rr));
            checkOutput($sformatf("tbl%0d_abReady", v), int'(abReady), int'(tbl[v].abr));
            applyStimulus(tbl[v].ar, tbl[v].rv, tbl[v].rp, tbl[v].av, tbl[v].ap);
        end

        $display("[TB] pop with dual push at count 10");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, 6'(20 + i), 1'b0, 6'd0);
        checkOutput("c10_count", int'(count), 10);
        checkOutput("c10_prf", int'(allocPrf), 20);
        applyStimulus(1'b1, 1'b1, 6'd30, 1'b1, 6'd31);
        checkOutput("c11_count", int'(count), 11);
        for (int i = 0; i < 11; i++) begin
            checkOutput("c11_order", int'(allocPrf), 21 + i);
            applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        end
        checkOutput("c11_emptyCount", int'(count), 0);
        checkOutput("c11_error", int'(error), 0);

        $display("[TB] fill to full");
        for (int k = 0; k < 62; k += 2)
            applyStimulus(1'b0, 1'b1, 6'(k), 1'b1, 6'(k + 1));
        applyStimulus(1'b0, 1'b1, 6'd62, 1'b0, 6'd0);
        checkOutput("c63_count", int'(count), 63);
        checkOutput("c63_relReady", int'(relReady), 1);
        checkOutput("c63_abReady", int'(abReady), 0);
        checkOutput("c63_prf", int'(allocPrf), 0);
        applyStimulus(1'b0, 1'b1, 6'd63, 1'b1, 6'd0);
        checkOutput("c64_count", int'(count), 64);
        checkOutput("c64_relReady", int'(relReady), 0);
        checkOutput("c64_abReady", int'(abReady), 0);
        checkOutput("c64_valid", int'(allocValid), 1);
        checkOutput("c64_error", int'(error), 0);
        applyStimulus(1'b0, 1'b1, 6'd1, 1'b1, 6'd2);
        checkOutput("c64_blockedCount", int'(count), 64);
        checkOutput("c64_blockedError", int'(error), 0);
        applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
        checkOutput("c63b_count", int'(count), 63);
        checkOutput("c63b_prf", int'(allocPrf), 1);
        checkOutput("c63b_abReady", int'(abReady), 0);

        $display("[TB] double free detection");
        resetDut();
        applyStimulus(1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
        checkOutput("dbl40_error", int'(error), 1);
        checkOutput("dbl40_count", int'(count), 33);
        repeat (5) applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        checkOutput("dbl40_sticky", int'(error), 1);
        resetDut();
        checkOutput("dbl_resetClears", int'(error), 0);
        applyStimulus(1'b0, 1'b1, 6'd5, 1'b1, 6'd5);
        checkOutput("samePrf_error", int'(error), 1);
        checkOutput("samePrf_count", int'(count), 34);

        $display("[TB] wrap burst then mid-burst reset");
        resetDut();
        freeQ.delete();
        heldQ.delete();
        for (int k = 32; k < 64; k++) freeQ.push_back(k);
        for (int k = 0; k < 32; k++) heldQ.push_back(k);
        for (int c = 0; c < 200; c++) begin
            int expPrf;
            int relNow;
            expPrf = freeQ.pop_front();
            relNow = heldQ.pop_front();
            checkOutput("wrap_prf", int'(allocPrf), expPrf);
            checkOutput("wrap_count", int'(count), 32);
            applyStimulus(1'b1, 1'b1, 6'(relNow), 1'b0, 6'd0);
            freeQ.push_back(relNow);
            heldQ.push_back(expPrf);
        end
        checkOutput("wrap_error", int'(error), 0);
        allocReady = 1'b1;
        relValid   = 1'b1;
        relPrf     = 6'(heldQ[0]);
        abValid    = 1'b1;
        abPrf      = 6'(heldQ[1]);
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        allocReady = 1'b0;
        relValid   = 1'b0;
        abValid    = 1'b0;
        reset      = 1'b1;
        #1;
        checkResetState("midReset");
        drainInitial("midDrain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
